// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package rf_pkg;

  localparam int DATA_W = 32;
  localparam int RNUM_W = 5;
  localparam int NREGS  = 16;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_M = 1'b1
  } req_e;

  typedef struct packed {
    logic              we;
    logic [RNUM_W-1:0] regnum;
    logic [DATA_W-1:0] data;
  } wport_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter (ALU vs load); ptr names the requester favoured in a conflict.
module rr_arb2
  import rf_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic a_valid,
  input  logic m_valid,
  output logic a_ready,
  output logic m_ready,
  output req_e grant
);

  req_e ptr;

  // Ready depends only on the other side's valid, never on the requester's own valid.
  assign a_ready = !m_valid || (ptr == REQ_A);
  assign m_ready = !a_valid || (ptr == REQ_M);
  assign grant   = (a_valid && a_ready) ? REQ_A : REQ_M;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr <= REQ_A;
    end else if (a_valid && a_ready) begin
      ptr <= REQ_M;
    end else if (m_valid && m_ready) begin
      ptr <= REQ_A;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file write port between ALU and load write-back, with a
// busy scoreboard of in-flight destinations and a sticky illegal-register flag.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int RNUM_W = rf_pkg::RNUM_W,
  parameter int NREGS  = rf_pkg::NREGS
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [RNUM_W-1:0] a_regnum,
  input  logic [DATA_W-1:0] a_data,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [RNUM_W-1:0] m_regnum,
  input  logic [DATA_W-1:0] m_data,
  input  logic              iss_valid,
  input  logic [RNUM_W-1:0] iss_regnum,
  output logic              rf_we,
  output logic [RNUM_W-1:0] rf_regnum,
  output logic [DATA_W-1:0] rf_data,
  output logic [NREGS-1:0]  busy,
  output logic              err
);

  localparam logic [RNUM_W:0] NREGS_X = (RNUM_W+1)'(NREGS);

  req_e              grant;
  logic              xfer;
  logic [RNUM_W-1:0] w_regnum;
  logic [DATA_W-1:0] w_data;
  logic              w_illegal;
  logic              w_write;
  logic              iss_illegal;
  logic              iss_set;
  logic [NREGS-1:0]  busy_next;
  wport_t            wport_q;

  rr_arb2 u_arb (
    .CLK     (CLK),
    .RST     (RST),
    .a_valid (a_valid),
    .m_valid (m_valid),
    .a_ready (a_ready),
    .m_ready (m_ready),
    .grant   (grant)
  );

  assign xfer     = (a_valid && a_ready) || (m_valid && m_ready);
  assign w_regnum = (grant == REQ_M) ? m_regnum : a_regnum;
  assign w_data   = (grant == REQ_M) ? m_data : a_data;

  assign w_illegal   = xfer && ({1'b0, w_regnum} >= NREGS_X);
  assign w_write     = xfer && !w_illegal && (w_regnum != '0);
  assign iss_illegal = iss_valid && ({1'b0, iss_regnum} >= NREGS_X);
  assign iss_set     = iss_valid && !iss_illegal && (iss_regnum != '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      wport_q <= '0;
    end else begin
      wport_q.we <= w_write;
      if (w_write) begin
        wport_q.regnum <= w_regnum;
        wport_q.data   <= w_data;
      end
    end
  end

  assign rf_we     = wport_q.we;
  assign rf_regnum = wport_q.regnum;
  assign rf_data   = wport_q.data;

  // Clear on commit first, then set on issue, so a newer in-flight write keeps the bit.
  always_comb begin
    busy_next = busy;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (rf_we && (rf_regnum == RNUM_W'(i))) begin
        busy_next[i] = 1'b0;
      end
      if (iss_set && (iss_regnum == RNUM_W'(i))) begin
        busy_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      busy <= '0;
      err  <= 1'b0;
    end else begin
      busy <= busy_next;
      if (w_illegal || iss_illegal) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a rule-level reference model checked every cycle.
module tb_rf_write_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        a_valid, m_valid, iss_valid;
  logic        a_ready, m_ready;
  logic [4:0]  a_regnum, m_regnum, iss_regnum;
  logic [31:0] a_data, m_data;
  logic        rf_we;
  logic [4:0]  rf_regnum;
  logic [31:0] rf_data;
  logic [15:0] busy;
  logic        err;

  int vecs = 0;
  int errs = 0;
  bit model_on = 0;

  rf_write_arbiter #(.DATA_W(32), .RNUM_W(5), .NREGS(16)) dut (
    .CLK(CLK), .RST(RST),
    .a_valid(a_valid), .a_ready(a_ready), .a_regnum(a_regnum), .a_data(a_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_regnum(m_regnum), .m_data(m_data),
    .iss_valid(iss_valid), .iss_regnum(iss_regnum),
    .rf_we(rf_we), .rf_regnum(rf_regnum), .rf_data(rf_data),
    .busy(busy), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: 0 = ALU favoured, 1 = load favoured.
  int          mdl_ptr;
  bit          mdl_we;
  int          mdl_regnum;
  logic [31:0] mdl_data;
  logic [15:0] mdl_busy;
  bit          mdl_err;

  always @(posedge CLK) begin
    bit ar, mr, ax, mx;
    int wr;
    logic [31:0] wd;
    logic [15:0] nb;
    if (RST) begin
      mdl_ptr = 0; mdl_we = 0; mdl_regnum = 0; mdl_data = '0; mdl_busy = '0; mdl_err = 0;
    end else begin
      ar = !m_valid || (mdl_ptr == 0);
      mr = !a_valid || (mdl_ptr == 1);
      ax = a_valid && ar;
      mx = m_valid && mr && !ax;
      wr = ax ? int'(a_regnum) : int'(m_regnum);
      wd = ax ? a_data : m_data;
      nb = mdl_busy;
      if (mdl_we) nb[mdl_regnum] = 1'b0;
      if (iss_valid && iss_regnum > 0 && iss_regnum < 16) nb[iss_regnum] = 1'b1;
      if ((ax || mx) && wr >= 16) mdl_err = 1;
      if (iss_valid && iss_regnum >= 16) mdl_err = 1;
      mdl_we = (ax || mx) && wr > 0 && wr < 16;
      if (mdl_we) begin
        mdl_regnum = wr;
        mdl_data   = wd;
      end
      mdl_busy = nb;
      if (ax) mdl_ptr = 1;
      else if (mx) mdl_ptr = 0;
    end
  end

  always @(negedge CLK) begin
    if (model_on) begin
      chk("a_ready", a_ready, !m_valid || (mdl_ptr == 0));
      chk("m_ready", m_ready, !a_valid || (mdl_ptr == 1));
      chk("rf_we", rf_we, mdl_we);
      chk("busy", busy, mdl_busy);
      chk("err", err, mdl_err);
      if (mdl_we) begin
        chk("rf_regnum", rf_regnum, mdl_regnum);
        chk("rf_data", rf_data, mdl_data);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    a_valid = 0; m_valid = 0; iss_valid = 0;
    a_regnum = '0; m_regnum = '0; iss_regnum = '0;
    a_data = '0; m_data = '0;
    tick(); tick();
    RST = 1'b0;
    model_on = 1;
    @(negedge CLK);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_regnum", rf_regnum, 0);
    chk("rst_rf_data", rf_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    tick();

    // single ALU write
    a_valid = 1; a_regnum = 5'd3; a_data = 32'h1234_5678;
    @(negedge CLK); chk("t1_a_ready", a_ready, 1);
    tick(); a_valid = 0;
    @(negedge CLK);
    chk("t1_rf_we", rf_we, 1);
    chk("t1_rf_regnum", rf_regnum, 3);
    chk("t1_rf_data", rf_data, 32'h1234_5678);
    tick();
    @(negedge CLK); chk("t1_rf_we_off", rf_we, 0);
    tick();

    // load write to r0: accepted, nothing written; leaves ALU favoured
    m_valid = 1; m_regnum = 5'd0; m_data = 32'hDEAD_BEEF;
    @(negedge CLK); chk("r0_m_ready", m_ready, 1);
    tick(); m_valid = 0;
    @(negedge CLK); chk("r0_rf_we", rf_we, 0);
    tick();

    // sustained conflict: grants alternate A,M,A,M with no bubble
    a_regnum = 5'd1; a_data = 32'h0000_00A1;
    m_regnum = 5'd2; m_data = 32'h0000_00B2;
    for (int k = 0; k < 5; k++) begin
      a_valid = (k < 4);
      m_valid = (k < 4);
      @(negedge CLK);
      if (k < 4) begin
        chk("rr_a_ready", a_ready, (k % 2) == 0);
        chk("rr_m_ready", m_ready, (k % 2) == 1);
      end
      if (k >= 1) begin
        chk("rr_rf_we", rf_we, 1);
        chk("rr_rf_regnum", rf_regnum, ((k - 1) % 2 == 0) ? 1 : 2);
      end
      tick();
    end

    // scoreboard set on issue, clear two cycles after the load transfer
    iss_valid = 1; iss_regnum = 5'd5;
    tick(); iss_valid = 0;
    @(negedge CLK); chk("sb5_set", busy[5], 1);
    tick();
    m_valid = 1; m_regnum = 5'd5; m_data = 32'h0000_0055;
    @(negedge CLK); chk("sb5_m_ready", m_ready, 1);
    tick(); m_valid = 0;
    @(negedge CLK);
    chk("sb5_rf_we", rf_we, 1);
    chk("sb5_still_busy", busy[5], 1);
    tick();
    @(negedge CLK); chk("sb5_clear", busy[5], 0);
    tick();

    // issue coinciding with commit of the same register keeps it busy
    iss_valid = 1; iss_regnum = 5'd7;
    a_valid = 1; a_regnum = 5'd7; a_data = 32'h0000_0077;
    tick(); a_valid = 0;
    @(negedge CLK);
    chk("sb7_rf_we", rf_we, 1);
    chk("sb7_rf_regnum", rf_regnum, 7);
    tick(); iss_valid = 0;
    @(negedge CLK); chk("sb7_busy", busy[7], 1);
    tick();

    // illegal register: accepted, dropped, err sticky
    a_valid = 1; a_regnum = 5'd20; a_data = 32'h0000_0020;
    @(negedge CLK);
    chk("r20_a_ready", a_ready, 1);
    chk("r20_err_before", err, 0);
    tick(); a_valid = 0;
    @(negedge CLK);
    chk("r20_rf_we", rf_we, 0);
    chk("r20_err", err, 1);
    tick(); tick(); tick();
    @(negedge CLK); chk("r20_err_sticky", err, 1);
    tick();

    // reset right after a transfer; load transfer during reset is lost
    a_valid = 1; a_regnum = 5'd4; a_data = 32'h0000_0044;
    iss_valid = 1; iss_regnum = 5'd9;
    tick();
    a_valid = 0; iss_valid = 0;
    RST = 1; m_valid = 1; m_regnum = 5'd6; m_data = 32'h0000_0066;
    @(negedge CLK); chk("rs_pending_we", rf_we, 1);
    tick();
    RST = 0; m_valid = 0;
    @(negedge CLK);
    chk("rs_rf_we", rf_we, 0);
    chk("rs_busy", busy, 0);
    chk("rs_err", err, 0);
    tick();
    a_valid = 1; a_regnum = 5'd1; a_data = 32'h0000_0101;
    m_valid = 1; m_regnum = 5'd2; m_data = 32'h0000_0202;
    @(negedge CLK);
    chk("rs_a_wins", a_ready, 1);
    chk("rs_m_loses", m_ready, 0);
    tick(); a_valid = 0; m_valid = 0;
    @(negedge CLK);
    chk("rs_rf_regnum", rf_regnum, 1);
    chk("rs_rf_data", rf_data, 32'h0000_0101);
    tick();

    // illegal issue destination sets err, leaves scoreboard alone
    iss_valid = 1; iss_regnum = 5'd17;
    tick(); iss_valid = 0;
    @(negedge CLK);
    chk("iss17_err", err, 1);
    chk("iss17_busy", busy, 0);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port (WE0/REGNUM2/data_in) between two write-back requesters: ALU (A) and memory-load (M). It uses valid/ready handshakes with round-robin arbitration and registered write-port outputs. It also keeps a busy scoreboard of destination registers with writes in flight, so issue logic can stall on read-after-write hazards. It sits between the execute/load stages and the register file.

## Interface
Parameters:
- DATA_W, 32, write data width
- RNUM_W, 5, register-number width
- NREGS, 16, implemented registers; indices ≥ NREGS are illegal

Ports (clock and reset first):
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high; clock CLK
- a_valid  in  1  ALU write request
- a_ready  out  1  ALU request accepted this cycle when a_valid&&a_ready
- a_regnum  in  RNUM_W  ALU destination
- a_data  in  DATA_W  ALU result
- m_valid, m_ready, m_regnum, m_data  same roles for the load requester
- iss_valid  in  1  an instruction with a destination register issued this cycle
- iss_regnum  in  RNUM_W  its destination
- rf_we  out  1  drives register file WE0
- rf_regnum  out  RNUM_W  drives REGNUM2
- rf_data  out  DATA_W  drives data_in
- busy  out  NREGS  bit i=1: write to register i pending
- err  out  1  sticky: illegal register number seen

## Operation
- Ready is independent of own valid:
  - a_ready = !m_valid || ptr==A
  - m_ready = !a_valid || ptr==M
- At most one transfer per cycle.
- Round-robin pointer ptr:
  - Reset value is A.
  - After any transfer, ptr points to the requester that did not transfer.
  - The winner of one conflict therefore loses the next.
- Transfer to regnum 0: accepted, rf_we stays 0. Register 0 reads as zero, so nothing is written.
- Transfer with regnum ≥ NREGS: accepted, dropped (rf_we=0), err set until RST.
- Legal transfer: rf_we/rf_regnum/rf_data are registered from the winning requester's fields.
- Scoreboard:
  - iss_valid with 0 < iss_regnum < NREGS sets busy[iss_regnum].
  - iss_regnum 0 is ignored.
  - iss_regnum ≥ NREGS sets err.
- busy[rf_regnum] clears in the cycle the write-port output has rf_we=1, i.e. the same edge the register file captures the data.
- Simultaneous set (issue) and clear (commit) of the same register: set wins, because a newer write is now in flight.
- No data buffering: a requester holds valid and its fields stable until it sees ready.

## Timing
- Transfer in cycle N → rf_we=1 with rf_regnum/rf_data throughout cycle N+1. The register file updates at the end of N+1.
- busy clear is visible in cycle N+2, the same cycle the new value is readable from the register file.
- Issue in cycle N → busy bit visible in cycle N+1.
- Back-to-back transfers: one write per cycle sustained, no bubbles.
- Reset values: rf_we=0, rf_regnum=0, rf_data=0, busy=0, err=0, ptr=A. a_ready/m_ready follow the combinational rule.
- RST mid-operation:
  - A transfer in the reset cycle is lost.
  - A registered write pending on rf_we is cancelled (rf_we=0 next cycle).
  - The register file is cleared by the same RST.

## Structure
- Shared package rf_pkg:
  - DATA_W, RNUM_W, NREGS constants
  - requester enum {REQ_A, REQ_M}
  - write-port struct {we, regnum, data}
- Sub-module rr_arb2:
  - 2-way round-robin arbiter holding ptr
  - inputs a_valid, m_valid
  - outputs a_ready, m_ready, grant
- Top holds the output register, the scoreboard and err.

## Test plan
- After RST, a_valid with regnum 3, data 0x1234_5678 → a_ready=1. Next cycle rf_we=1, rf_regnum=3, rf_data=0x12345678. Following cycle rf_we=0.
- a_valid and m_valid held for 4 cycles with regnums 1 and 2 → grants A,M,A,M. rf_regnum sequence 1,2,1,2 with no idle cycle.
- Issue regnum 5 in cycle 0 → busy[5]=1 from cycle 1. M transfer to 5 in cycle 3 → rf_we in cycle 4, busy[5]=0 in cycle 5.
- Issue regnum 7 in the same cycle rf_we=1 with rf_regnum=7 → busy[7] remains 1.
- Transfer to regnum 0 → accepted, rf_we stays 0. Transfer to regnum 20 → accepted, rf_we=0, err=1 until RST.
- RST asserted in the cycle after a transfer → rf_we=0, busy=0, err=0 next cycle, and ptr=A (A wins the next conflict).
